// File: rtl/dmem_dump_pkg.sv
// rtl/dmem_dump_pkg.sv - shared types and constants for the data-memory dump reader
package dmem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    OUT,
    DONE
  } dump_state_t;

  // Data memory words are 8 bytes wide.
  localparam int WORD_STRIDE_SHIFT = 3;

endpackage

// File: rtl/dmem_dump_reader.sv
// rtl/dmem_dump_reader.sv - sequential burst reader on data-memory port 2 with valid/ready output
module dmem_dump_reader
  import dmem_dump_pkg::*;
#(
  parameter int DMEM_SIZE = 1024,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int CNT_W     = $clog2(DMEM_SIZE) + 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  base_idx,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              ren_ext_2,
  output logic              wen_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] SIZE_C     = CNT_W'(DMEM_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(DMEM_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  dump_state_t       state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]  count_clamped;
  logic [CNT_W-1:0]  base_wrapped;

  // Oversized counts saturate to a full-memory dump; out-of-range bases fold back into the array.
  always_comb begin
    count_clamped = (word_count > SIZE_C) ? SIZE_C : word_count;
    base_wrapped  = (base_idx >= SIZE_C) ? (base_idx - SIZE_C) : base_idx;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      remain_q <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      dout_q   <= dout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    dout_d   = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            idx_d    = base_wrapped;
            remain_d = count_clamped;
            state_d  = RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        dout_d   = rdata_ext_2;
        remain_d = remain_q - ONE_C;
        idx_d    = (idx_q == LAST_IDX_C) ? '0 : (idx_q + ONE_C);
        state_d  = OUT;
      end
      OUT: begin
        if (dout_ready) begin
          state_d = (remain_q == '0) ? DONE : RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ren_ext_2   = (state_q == RD);
  assign addr_ext_2  = ren_ext_2 ? (ADDR_W'(idx_q) << WORD_STRIDE_SHIFT) : '0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = '0;
  assign dout        = dout_q;
  assign dout_valid  = (state_q == OUT);
  assign dout_last   = dout_valid && (remain_q == '0);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb/tb_dmem_dump_reader.sv - directed self-checking bench for dmem_dump_reader
module tb_dmem_dump_reader;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [10:0] base_idx;
  logic [10:0] word_count;
  logic [63:0] addr_ext_2;
  logic        ren_ext_2;
  logic        wen_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  logic [63:0] mem [1024];
  logic [63:0] exp12 [12];

  logic [63:0] words [$];
  logic [63:0] addrs [$];
  int          last_cnt;
  int          last_pos;
  int          done_cyc;
  int          stall_bad;
  int          busy_bad;
  int          timed_out;

  dmem_dump_reader dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .base_idx    (base_idx),
    .word_count  (word_count),
    .addr_ext_2  (addr_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wen_ext_2   (wen_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[12:3]];
  end

  // Drives one start and records the burst cycle by cycle; mode 0 = ready held high,
  // mode 1 = ready on every third OUT cycle. hold_start keeps start high with a different request.
  task automatic run_burst(input logic [10:0] base, input logic [10:0] cnt, input int mode,
                           input int hold_start, input int max_cyc);
    logic        prev_stall;
    logic [63:0] prev_dout;
    logic        prev_last;
    int          ocnt;
    words.delete();
    addrs.delete();
    last_cnt = 0; last_pos = -1; done_cyc = -1; stall_bad = 0; busy_bad = 0; timed_out = 0;
    prev_stall = 1'b0; prev_dout = '0; prev_last = 1'b0; ocnt = 0;
    @(negedge clk);
    base_idx = base; word_count = cnt; start = 1'b1; dout_ready = (mode == 0);
    @(posedge clk);
    @(negedge clk);
    if (hold_start != 0) begin
      base_idx = 11'd100; word_count = 11'd5;
    end else begin
      start = 1'b0;
    end
    for (int c = 1; c <= max_cyc; c++) begin
      if (mode == 1) begin
        dout_ready = dout_valid && ((ocnt % 3) == 2);
        if (dout_valid) ocnt++;
      end
      if (prev_stall && (dout !== prev_dout || dout_last !== prev_last || dout_valid !== 1'b1))
        stall_bad++;
      if (ren_ext_2) addrs.push_back(addr_ext_2);
      if (busy !== 1'b1) busy_bad++;
      if (dout_valid && dout_ready) begin
        words.push_back(dout);
        if (dout_last) begin
          last_cnt++;
          last_pos = words.size() - 1;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
      if (done) begin
        done_cyc = c;
        start = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) timed_out = 1;
    start = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; start = 1'b0; base_idx = '0; word_count = '0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (ren_ext_2 !== 1'b0) begin fails++; $display("FAIL reset_ren got %b want 0", ren_ext_2); end
    tests++; if (addr_ext_2 !== 64'd0) begin fails++; $display("FAIL reset_addr got %h want 0", addr_ext_2); end
    tests++; if (dout_valid !== 1'b0 || dout_last !== 1'b0) begin fails++; $display("FAIL reset_valid got %b%b want 00", dout_valid, dout_last); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    tests++; if (dout !== 64'd0) begin fails++; $display("FAIL reset_dout got %h want 0", dout); end
    tests++; if (wen_ext_2 !== 1'b0 || wdata_ext_2 !== 64'd0) begin fails++; $display("FAIL reset_wr got %b %h want 0 0", wen_ext_2, wdata_ext_2); end
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_burst(11'd35, 11'd12, 0, 0, 100);
    tests++; if (timed_out !== 0) begin fails++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
    tests++; if (words.size() !== 12) begin fails++; $display("FAIL basic_nwords got %0d want 12", words.size()); end
    for (int i = 0; i < 12 && i < words.size(); i++) begin
      tests++; if (words[i] !== exp12[i]) begin fails++; $display("FAIL basic_word%0d got %h want %h", i, words[i], exp12[i]); end
    end
    tests++; if (addrs.size() !== 12) begin fails++; $display("FAIL basic_naddr got %0d want 12", addrs.size()); end
    for (int i = 0; i < 12 && i < addrs.size(); i++) begin
      tests++; if (addrs[i] !== 64'h118 + 64'(8 * i)) begin fails++; $display("FAIL basic_addr%0d got %h want %h", i, addrs[i], 64'h118 + 64'(8 * i)); end
    end
    tests++; if (last_cnt !== 1 || last_pos !== 11) begin fails++; $display("FAIL basic_last got cnt %0d pos %0d want 1 11", last_cnt, last_pos); end
    tests++; if (done_cyc !== 37) begin fails++; $display("FAIL basic_done_cycle got %0d want 37", done_cyc); end
    tests++; if (busy_bad !== 0) begin fails++; $display("FAIL basic_busy got %0d low cycles want 0", busy_bad); end
  endtask

  task automatic test_backpressure();
    run_burst(11'd35, 11'd12, 1, 0, 200);
    tests++; if (timed_out !== 0) begin fails++; $display("FAIL bp_timeout got %0d want 0", timed_out); end
    tests++; if (words.size() !== 12) begin fails++; $display("FAIL bp_nwords got %0d want 12", words.size()); end
    for (int i = 0; i < 12 && i < words.size(); i++) begin
      tests++; if (words[i] !== exp12[i]) begin fails++; $display("FAIL bp_word%0d got %h want %h", i, words[i], exp12[i]); end
    end
    tests++; if (addrs.size() !== 12) begin fails++; $display("FAIL bp_naddr got %0d want 12", addrs.size()); end
    tests++; if (stall_bad !== 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", stall_bad); end
    tests++; if (done_cyc !== 61) begin fails++; $display("FAIL bp_done_cycle got %0d want 61", done_cyc); end
    tests++; if (last_pos !== 11) begin fails++; $display("FAIL bp_last got %0d want 11", last_pos); end
  endtask

  task automatic test_wrap();
    logic [63:0] ea [4];
    logic [63:0] ew [4];
    ea = '{64'h1FF0, 64'h1FF8, 64'h0, 64'h8};
    ew = '{mem[1022], mem[1023], mem[0], mem[1]};
    run_burst(11'd1022, 11'd4, 0, 0, 40);
    tests++; if (addrs.size() !== 4 || words.size() !== 4) begin fails++; $display("FAIL wrap_count got %0d/%0d want 4/4", addrs.size(), words.size()); end
    for (int i = 0; i < 4 && i < addrs.size() && i < words.size(); i++) begin
      tests++; if (addrs[i] !== ea[i]) begin fails++; $display("FAIL wrap_addr%0d got %h want %h", i, addrs[i], ea[i]); end
      tests++; if (words[i] !== ew[i]) begin fails++; $display("FAIL wrap_word%0d got %h want %h", i, words[i], ew[i]); end
    end
    tests++; if (done_cyc !== 13) begin fails++; $display("FAIL wrap_done_cycle got %0d want 13", done_cyc); end
  endtask

  task automatic test_zero();
    run_burst(11'd7, 11'd0, 0, 0, 10);
    tests++; if (done_cyc !== 1) begin fails++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
    tests++; if (addrs.size() !== 0) begin fails++; $display("FAIL zero_ren got %0d reads want 0", addrs.size()); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL zero_after got busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_clamp();
    run_burst(11'd0, 11'd1500, 0, 0, 3200);
    tests++; if (words.size() !== 1024) begin fails++; $display("FAIL clamp_nwords got %0d want 1024", words.size()); end
    tests++; if (done_cyc !== 3073) begin fails++; $display("FAIL clamp_done_cycle got %0d want 3073", done_cyc); end
    if (words.size() == 1024) begin
      tests++; if (words[1023] !== mem[1023] || words[0] !== mem[0]) begin fails++; $display("FAIL clamp_ends got %h %h want %h %h", words[0], words[1023], mem[0], mem[1023]); end
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    int bad;
    @(negedge clk);
    base_idx = 11'd35; word_count = 11'd12; start = 1'b1; dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    for (int c = 1; c <= 100; c++) begin
      if (dout_valid) nv++;
      if (nv == 5) break;
      @(negedge clk);
    end
    tests++; if (nv !== 5) begin fails++; $display("FAIL rstmid_reach got %0d words want 5", nv); end
    tests++; if (dout !== 64'h1EA) begin fails++; $display("FAIL rstmid_word5 got %h want 1ea", dout); end
    arst_n = 1'b0;
    #1;
    tests++; if (dout_valid !== 1'b0 || dout !== 64'd0 || dout_last !== 1'b0) begin fails++; $display("FAIL rstmid_out got v%b d%h l%b want 0", dout_valid, dout, dout_last); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || ren_ext_2 !== 1'b0 || addr_ext_2 !== 64'd0) begin fails++; $display("FAIL rstmid_ctl got b%b d%b r%b a%h want 0", busy, done, ren_ext_2, addr_ext_2); end
    @(negedge clk);
    arst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || ren_ext_2) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rstmid_resume got %0d active cycles want 0", bad); end
    dout_ready = 1'b1;
    run_burst(11'd40, 11'd3, 0, 0, 50);
    tests++; if (words.size() !== 3) begin fails++; $display("FAIL rstmid_new_n got %0d want 3", words.size()); end
    for (int i = 0; i < 3 && i < words.size(); i++) begin
      tests++; if (words[i] !== mem[40 + i]) begin fails++; $display("FAIL rstmid_new_word%0d got %h want %h", i, words[i], mem[40 + i]); end
    end
    tests++; if (done_cyc !== 10) begin fails++; $display("FAIL rstmid_new_done got %0d want 10", done_cyc); end
  endtask

  task automatic test_start_busy();
    int bad;
    run_burst(11'd35, 11'd3, 0, 1, 50);
    tests++; if (words.size() !== 3) begin fails++; $display("FAIL busy_start_n got %0d want 3", words.size()); end
    for (int i = 0; i < 3 && i < words.size(); i++) begin
      tests++; if (words[i] !== exp12[i]) begin fails++; $display("FAIL busy_start_word%0d got %h want %h", i, words[i], exp12[i]); end
    end
    tests++; if (done_cyc !== 10 || addrs.size() !== 3) begin fails++; $display("FAIL busy_start_timing got done %0d reads %0d want 10 3", done_cyc, addrs.size()); end
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy || ren_ext_2) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL busy_start_extra got %0d active cycles want 0", bad); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rdata_ext_2 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    exp12 = '{64'h258, 64'h2B2, 64'h30C, 64'h1A9, 64'h1EA, 64'h22B,
              64'hFA,  64'h122, 64'h14A, 64'h4B,  64'h5A,  64'h69};
    for (int i = 0; i < 12; i++) mem[35 + i] = exp12[i];
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_clamp();
    test_reset_mid();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Hardware reader for the CPU data memory's external port 2. On `start` it issues one sequential burst of read requests on the `addr_ext_2`/`ren_ext_2` port and returns each 64-bit word on a valid/ready output stream. It sits beside the `cpu` top level, driving that port in place of the loader once the program has stopped. Its purpose is to dump result regions, such as the Mult4 output matrix, without bench-side polling.

## Interface
- `DMEM_SIZE`, 1024: data memory depth in 64-bit words.
- `ADDR_W`, 64: width of `addr_ext_2`.
- `DATA_W`, 64: data word width.
- `CNT_W`, `$clog2(DMEM_SIZE)+1`: width of the word index and the word count.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `arst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request; sampled only in IDLE.
- `base_idx`, in, CNT_W: first word index; sampled with `start`.
- `word_count`, in, CNT_W: number of words, 0..DMEM_SIZE; sampled with `start`.
- `addr_ext_2`, out, ADDR_W: byte address, always `word_index << 3`.
- `ren_ext_2`, out, 1: read strobe to data memory.
- `wen_ext_2`, out, 1: constant 0.
- `wdata_ext_2`, out, DATA_W: constant 0.
- `rdata_ext_2`, in, DATA_W: memory read data, valid the cycle after `ren_ext_2`.
- `dout`, out, DATA_W: captured word.
- `dout_valid`, out, 1: `dout` is valid.
- `dout_ready`, in, 1: sink accepts.
- `dout_last`, out, 1: final word of the burst; qualified by `dout_valid`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at end of burst.

## Operation
- States are IDLE, RD, CAP, OUT and DONE.
- IDLE:
  - `start & word_count != 0`: latch `base_idx` into `idx` and `word_count` into `remain`, then go to RD.
  - `start & word_count == 0`: go to DONE directly; no memory access.
- RD:
  - drive `ren_ext_2 = 1` and `addr_ext_2 = idx << 3`.
  - next state is CAP.
- CAP:
  - register `rdata_ext_2` into `dout`.
  - decrement `remain`.
  - advance `idx = (idx + 1) mod DMEM_SIZE`; the address wraps from word DMEM_SIZE-1 to word 0.
  - next state is OUT.
- OUT:
  - hold `dout_valid = 1` and keep `dout` stable until `dout_ready`.
  - `dout_last = (remain == 0)`.
  - on handshake: go to DONE if `remain == 0`, else go to RD.
- DONE: assert `done` for exactly one cycle, then go to IDLE.
- `start` is ignored in every state except IDLE; no queuing.
- `word_count > DMEM_SIZE` is clamped to DMEM_SIZE.
- `ren_ext_2` is never asserted outside RD. `addr_ext_2` is 0 whenever `ren_ext_2` is low.

## Timing
- Reset value of every output is 0, and the state is IDLE.
  - Reset asserted mid-burst aborts immediately.
  - No `done` pulse is produced for an aborted burst.
  - The burst is not resumed after reset release.
- Cycle-by-cycle for a burst, with `start` sampled at edge 0:
  - cycle 1: RD, `ren_ext_2` high.
  - cycle 2: CAP.
  - cycle 3: OUT, first `dout_valid`.
- With `dout_ready` held high, each word takes 3 cycles.
  - A burst of N words ends with `done` in cycle 3N+1.
  - `busy` is high in cycles 1..3N+1.
- Zero-count start: `done` in cycle 1; `busy` high in cycle 1 only.
- Backpressure stalls only in OUT. `dout`, `dout_last` and `dout_valid` must not change while `dout_valid & !dout_ready`.
- `dout_ready` asserted outside OUT has no effect.

## Structure
- Package `dmem_dump_pkg`:
  - state enum `dump_state_t` (IDLE, RD, CAP, OUT, DONE).
  - constant `WORD_STRIDE_SHIFT = 3`.
- Single module; no sub-module.
- Index/remain counters and the output register are inline.
- Expected 150–250 lines of RTL.

## Test plan
- Preload dmem[35..46] with 0x258, 0x2B2, 0x30C, 0x1A9, 0x1EA, 0x22B, 0xFA, 0x122, 0x14A, 0x4B, 0x5A, 0x69.
  - Stimulus: `start`, base_idx 35, count 12, `dout_ready` = 1.
  - Required: 12 words in that order; addresses 0x118..0x170; `dout_last` only on 0x69; `done` in cycle 37.
- Same burst with `dout_ready` toggling on a 1-in-3 pattern.
  - Required: identical word sequence; `dout` stable during each stall; no extra `ren_ext_2` pulses.
- base_idx 1022, count 4.
  - Required: addresses 0x1FF0, 0x1FF8, 0x0, 0x8.
- count 0.
  - Required: `done` pulse in cycle 1; `ren_ext_2` never high.
- Reset asserted during OUT of word 5 of 12.
  - Required: all outputs 0 at once; after release, no `done`; a new `start` runs cleanly from its own base.
- Second `start` asserted while busy.
  - Required: ignored; exactly one burst completes.
